// File: rtl/vadd_self_test_pkg.sv
// vadd_self_test_pkg: shared sizes, vector/test types and the replay table with golden sums
package vadd_self_test_pkg;

  localparam int LANES     = 4;
  localparam int WIDTH     = 8;
  localparam int NUM_TESTS = 8;
  localparam int IDX_W     = $clog2(NUM_TESTS);

  typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

  typedef struct packed {
    vec_t a;
    vec_t b;
    vec_t y;
  } test_t;

  // Lanes are written lane3..lane0; every golden lane is (a + b) mod 2^WIDTH.
  localparam test_t TABLE [NUM_TESTS] = '{
    '{a: 32'h01_02_03_04, b: 32'h10_20_30_40, y: 32'h11_22_33_44},
    '{a: 32'hFF_FF_FF_FF, b: 32'h01_01_01_01, y: 32'h00_00_00_00},
    '{a: 32'h00_00_00_00, b: 32'h00_00_00_00, y: 32'h00_00_00_00},
    '{a: 32'h80_7F_01_FE, b: 32'h80_01_FF_01, y: 32'h00_80_00_FF},
    '{a: 32'h12_34_56_78, b: 32'h87_65_43_21, y: 32'h99_99_99_99},
    '{a: 32'hAA_55_AA_55, b: 32'h55_AA_56_AB, y: 32'hFF_FF_00_00},
    '{a: 32'hC0_DE_BE_EF, b: 32'h41_23_43_12, y: 32'h01_01_01_01},
    '{a: 32'h7F_7F_7F_7F, b: 32'h7F_80_81_01, y: 32'hFE_FF_00_80}
  };

endpackage

// File: rtl/vadd_self_test_vadd.sv
// vadd: LANES-wide modular adder, registered operands then one output stage (two with VADD_SELF_TEST_EXTRA_STAGE_EN)
module vadd
  import vadd_self_test_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  input  vec_t a,
  input  vec_t b,
  output logic out_valid,
  output vec_t y
);

  logic v_q;
  vec_t a_q;
  vec_t b_q;
  vec_t sum;

  // capture operands and their valid flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
    end else begin
      v_q <= in_valid;
      a_q <= a;
      b_q <= b;
    end
  end

  // independent per-lane sums, carry out of each lane dropped
  always_comb begin
    sum = '0;
    for (int l = 0; l < LANES; l++) sum[l] = a_q[l] + b_q[l];
  end

`ifdef VADD_SELF_TEST_EXTRA_STAGE_EN
  logic v_1;
  vec_t y_1;

  // two output stages
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      v_1       <= 1'b0;
      y_1       <= '0;
      out_valid <= 1'b0;
      y         <= '0;
    end else begin
      v_1       <= v_q;
      y_1       <= sum;
      out_valid <= v_1;
      y         <= y_1;
    end
  end
`else
  // single output stage
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      y         <= '0;
    end else begin
      out_valid <= v_q;
      y         <= sum;
    end
  end
`endif

endmodule

// File: rtl/vadd_self_test.sv
// vadd_self_test: replays TABLE through vadd and flags sticky fail/finish; VADD_SELF_TEST_EXTRA_STAGE_EN deepens vadd by one stage
module vadd_self_test
  import vadd_self_test_pkg::*;
(
  input  logic clock,
  input  logic reset,
  output logic fail,
  output logic finish
);

  logic [IDX_W:0]   idx;
  logic [IDX_W-1:0] tix;
  logic             issue;
  logic             out_valid;
  vec_t             y;
  logic             g0_v;
  logic [IDX_W-1:0] g0_i;
  vec_t             g0_y;
  logic             chk_valid;
  logic [IDX_W-1:0] chk_idx;
  vec_t             gold_chk;
  logic             hit;
  logic             mismatch;
  logic             last_ok;

  assign tix   = idx[IDX_W-1:0];
  assign issue = (idx != (IDX_W + 1)'(NUM_TESTS)) && !fail;

  vadd u_vadd (
    .clock    (clock),
    .reset    (reset),
    .in_valid (issue),
    .a        (TABLE[tix].a),
    .b        (TABLE[tix].b),
    .out_valid(out_valid),
    .y        (y)
  );

  // issue index walks the table once and parks at NUM_TESTS
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) idx <= '0;
    else if (issue) idx <= idx + 1'b1;
  end

  // golden stage matching vadd's operand register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      g0_v <= 1'b0;
      g0_i <= '0;
      g0_y <= '0;
    end else begin
      g0_v <= issue;
      g0_i <= tix;
      g0_y <= TABLE[tix].y;
    end
  end

`ifdef VADD_SELF_TEST_EXTRA_STAGE_EN
  logic             g1_v;
  logic [IDX_W-1:0] g1_i;
  vec_t             g1_y;

  // golden stages matching both vadd output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      g1_v      <= 1'b0;
      g1_i      <= '0;
      g1_y      <= '0;
      chk_valid <= 1'b0;
      chk_idx   <= '0;
      gold_chk  <= '0;
    end else begin
      g1_v      <= g0_v;
      g1_i      <= g0_i;
      g1_y      <= g0_y;
      chk_valid <= g1_v;
      chk_idx   <= g1_i;
      gold_chk  <= g1_y;
    end
  end
`else
  // golden stage matching the vadd output register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chk_valid <= 1'b0;
      chk_idx   <= '0;
      gold_chk  <= '0;
    end else begin
      chk_valid <= g0_v;
      chk_idx   <= g0_i;
      gold_chk  <= g0_y;
    end
  end
`endif

  assign hit      = out_valid && chk_valid;
  assign mismatch = hit && (y != gold_chk);
  assign last_ok  = hit && (y == gold_chk) && (chk_idx == IDX_W'(NUM_TESTS - 1));

  // sticky verdict flags; whichever sets first locks the other out
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fail   <= 1'b0;
      finish <= 1'b0;
    end else begin
      fail   <= fail | (mismatch & ~finish);
      finish <= finish | (last_ok & ~fail);
    end
  end

endmodule

// File: tb/tb_vadd_self_test.sv
// tb_vadd_self_test: random reset-pulse replays checked against an arithmetic model of the table
module tb_vadd_self_test;

  localparam int N = 8;
`ifdef VADD_SELF_TEST_EXTRA_STAGE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic fail;
  logic finish;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] opa [N] = '{32'h01020304, 32'hFFFFFFFF, 32'h00000000, 32'h807F01FE,
                          32'h12345678, 32'hAA55AA55, 32'hC0DEBEEF, 32'h7F7F7F7F};
  logic [31:0] opb [N] = '{32'h10203040, 32'h01010101, 32'h00000000, 32'h8001FF01,
                          32'h87654321, 32'h55AA56AB, 32'h41234312, 32'h7F808101};

  vadd_self_test dut (
    .clock (clock),
    .reset (reset),
    .fail  (fail),
    .finish(finish)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_sum(input int k);
    logic [31:0] r;
    int s;
    r = '0;
    for (int l = 0; l < 4; l++) begin
      s = int'((opa[k] >> (8 * l)) & 32'hFF) + int'((opb[k] >> (8 * l)) & 32'hFF);
      r[8*l+:8] = 8'(s % 256);
    end
    return r;
  endfunction

  task automatic check_edge(input int e);
    int  k;
    logic ov;
    k  = e - LAT;
    ov = (k >= 0) && (k < N);
    check($sformatf("finish@%0d", e), 32'(finish), 32'(e >= N + LAT));
    check($sformatf("fail@%0d", e), 32'(fail), 32'd0);
    check($sformatf("out_valid@%0d", e), 32'(dut.u_vadd.out_valid), 32'(ov));
    if (ov) check($sformatf("sum%0d", k), dut.u_vadd.y, model_sum(k));
    if (k == 1) check("wrap1", dut.u_vadd.y, 32'h0);
  endtask

  task automatic rst_off();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic run(input int n);
    for (int e = 0; e < n; e++) begin
      @(posedge clock);
      #1;
      check_edge(e);
    end
  endtask

  task automatic pulse_reset(input int hold);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_finish", 32'(finish), 32'd0);
    check("rst_out_valid", 32'(dut.u_vadd.out_valid), 32'd0);
    repeat (hold) @(posedge clock);
  endtask

  initial begin
    repeat (20) begin
      @(posedge clock);
      #1;
      check("hold_fail", 32'(fail), 32'd0);
      check("hold_finish", 32'(finish), 32'd0);
    end
    rst_off();
    run(N + LAT + 4);
    pulse_reset(2);
    rst_off();
    run(5);
    pulse_reset(3);
    rst_off();
    run(N + LAT + 3);
    repeat (4) begin
      pulse_reset(int'($urandom_range(1, 4)));
      rst_off();
      run(int'($urandom_range(1, N + LAT + 2)));
    end
    pulse_reset(2);
    rst_off();
    run(4 + LAT);
    force dut.gold_chk = 32'h008000FE;
    @(posedge clock);
    #1;
    release dut.gold_chk;
    check("inj_fail", 32'(fail), 32'd1);
    check("inj_finish", 32'(finish), 32'd0);
    repeat (N + 2) begin
      @(posedge clock);
      #1;
      check("inj_fail_hold", 32'(fail), 32'd1);
      check("inj_finish_hold", 32'(finish), 32'd0);
    end
    pulse_reset(2);
    rst_off();
    run(N + LAT + 3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
